// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and issues sequential fetches to a one-cycle-latency memory.
// Returned words sit in a 2-entry queue that feeds decode over valid/ready; redirects squash everything.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned OCC_W  = 3;

    logic [XLEN-1:0]  f_pc_q, f_pc_d;
    logic             inf_q, inf_d;
    logic [XLEN-1:0]  inf_pc_q, inf_pc_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hd_q, hd_d;
    logic [XLEN-1:0]  buf_pc_q    [DEPTH];
    logic [XLEN-1:0]  buf_pc_d    [DEPTH];
    logic [XLEN-1:0]  buf_instr_q [DEPTH];
    logic [XLEN-1:0]  buf_instr_d [DEPTH];

    logic             pop;
    logic             push;
    logic             req;
    logic             tail;
    logic [OCC_W-1:0] occ;

    // Handshake, credit check and next-state for PC, in-flight tracker and queue.
    always_comb begin
        f_pc_d      = f_pc_q;
        inf_d       = 1'b0;
        inf_pc_d    = inf_pc_q;
        sq_d        = 1'b0;
        cnt_d       = cnt_q;
        hd_d        = hd_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;

        pop  = (cnt_q != CNT_W'(0)) & i_ready & ~i_redirect;
        occ  = OCC_W'(cnt_q) + OCC_W'(inf_q) - OCC_W'(pop);
        req  = ~i_rst & ~i_redirect & (occ < OCC_W'(2));
        push = inf_q & ~sq_q & ~i_redirect;
        tail = hd_q ^ cnt_q[0];

        if (i_redirect) begin
            f_pc_d = i_redirect_pc & ~XLEN'(3);
            cnt_d  = '0;
        end else begin
            if (req) begin
                f_pc_d   = f_pc_q + XLEN'(4);
                inf_d    = 1'b1;
                inf_pc_d = f_pc_q;
            end
            // With cnt=2 a push only happens alongside a pop, so the tail is the slot being freed.
            if (push) begin
                buf_pc_d[tail]    = inf_pc_q;
                buf_instr_d[tail] = i_imem_rdata;
            end
            if (pop) begin
                hd_d = ~hd_q;
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_pc_q   <= RESET_PC;
            inf_q    <= 1'b0;
            inf_pc_q <= '0;
            sq_q     <= 1'b0;
            cnt_q    <= '0;
            hd_q     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            f_pc_q      <= f_pc_d;
            inf_q       <= inf_d;
            inf_pc_q    <= inf_pc_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            hd_q        <= hd_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = f_pc_q;
    assign o_valid     = (cnt_q != CNT_W'(0));
    assign o_instr     = buf_instr_q[hd_q];
    assign o_pc        = buf_pc_q[hd_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a mid-operation reset sequence.
// Memory model returns word (addr >> 2) one cycle after each request.
module tb_fetch_unit;

    logic        clk;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    int checks;
    int failures;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_rdata (i_imem_rdata),
        .o_valid      (o_valid),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .i_ready      (i_ready),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_imem_req) i_imem_rdata <= o_imem_addr >> 2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rd, input logic [31:0] rpc,
                       input logic req, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc, input logic [31:0] ins);
        vec_t v;
        v.ready = rdy; v.redir = rd; v.rpc = rpc;
        v.exp_req = req; v.exp_addr = addr;
        v.exp_valid = vld; v.exp_pc = pc; v.exp_instr = ins;
        vecs.push_back(v);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, ".req"},  32'(o_imem_req), 32'(v.exp_req));
        chk({tag, ".addr"}, o_imem_addr,     v.exp_addr);
        chk({tag, ".valid"}, 32'(o_valid),   32'(v.exp_valid));
        if (v.exp_valid) begin
            chk({tag, ".pc"},    o_pc,    v.exp_pc);
            chk({tag, ".instr"}, o_instr, v.exp_instr);
        end
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        i_rst = 1'b1;
        i_ready = 1'b1;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_imem_rdata = '0;

        // Startup stream
        add(1, 0, 0, 1, 32'h0,  0, 0, 0);
        add(1, 0, 0, 1, 32'h4,  0, 0, 0);
        add(1, 0, 0, 1, 32'h8,  1, 32'h0, 32'h0);
        add(1, 0, 0, 1, 32'hC,  1, 32'h4, 32'h1);
        add(1, 0, 0, 1, 32'h10, 1, 32'h8, 32'h2);
        // Backpressure for 6 cycles: two entries held, requests stop
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 32'h14, 1, 32'hC, 32'h3);
        add(1, 0, 0, 1, 32'h14, 1, 32'hC,  32'h3);
        add(1, 0, 0, 1, 32'h18, 1, 32'h10, 32'h4);
        add(1, 0, 0, 1, 32'h1C, 1, 32'h14, 32'h5);
        // Fill to two entries, then redirect to 0x103 while stalled
        add(0, 0, 0,            0, 32'h20, 1, 32'h18, 32'h6);
        add(0, 1, 32'h0000_0103, 0, 32'h20, 1, 32'h18, 32'h6);
        add(1, 0, 0, 1, 32'h100, 0, 0, 0);
        add(1, 0, 0, 1, 32'h104, 0, 0, 0);
        add(1, 0, 0, 1, 32'h108, 1, 32'h100, 32'h40);
        add(1, 0, 0, 1, 32'h10C, 1, 32'h104, 32'h41);
        // Redirect with pop and arriving response; target near the wrap point
        add(1, 1, 32'hFFFF_FFF8, 0, 32'h110, 1, 32'h108, 32'h42);
        add(1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0);
        add(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFF8, 32'h3FFF_FFFE);
        add(1, 0, 0, 1, 32'h4, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        add(1, 0, 0, 1, 32'h8, 1, 32'h0, 32'h0);
        add(1, 0, 0, 1, 32'hC, 1, 32'h4, 32'h1);

        repeat (3) @(negedge clk);
        chk("reset.valid", 32'(o_valid),    32'h0);
        chk("reset.req",   32'(o_imem_req), 32'h0);
        chk("reset.addr",  o_imem_addr,     32'h0);
        chk("reset.pc",    o_pc,            32'h0);
        chk("reset.instr", o_instr,         32'h0);

        i_rst = 1'b0;
        foreach (vecs[i]) begin
            v = vecs[i];
            i_ready       = v.ready;
            i_redirect    = v.redir;
            i_redirect_pc = v.rpc;
            #1;
            check_vec($sformatf("vec%0d", i), v);
            @(negedge clk);
        end

        // Mid-operation reset between clock edges while streaming
        i_ready = 1'b1;
        i_redirect = 1'b0;
        #1;
        chk("pre_rst.valid", 32'(o_valid), 32'h1);
        chk("pre_rst.pc",    o_pc,         32'h8);
        #1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst.valid", 32'(o_valid),    32'h0);
        chk("mid_rst.req",   32'(o_imem_req), 32'h0);
        @(negedge clk);
        chk("mid_rst.hold_valid", 32'(o_valid), 32'h0);
        i_rst = 1'b0;
        #1;
        chk("restart0.req",   32'(o_imem_req), 32'h1);
        chk("restart0.addr",  o_imem_addr,     32'h0);
        chk("restart0.valid", 32'(o_valid),    32'h0);
        @(negedge clk);
        #1;
        chk("restart1.valid", 32'(o_valid), 32'h0);
        chk("restart1.addr",  o_imem_addr,  32'h4);
        @(negedge clk);
        #1;
        chk("restart2.valid", 32'(o_valid), 32'h1);
        chk("restart2.pc",    o_pc,         32'h0);
        chk("restart2.instr", o_instr,      32'h0);
        @(negedge clk);
        #1;
        chk("restart3.pc",    o_pc,    32'h4);
        chk("restart3.instr", o_instr, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
